muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit with its own control FSM. Sits beside the ALU in the Execute stage of the pipelined RISC-V core.
- The main decoder routes M-extension ops (op=0110011, funct7=0000001) here. The block stalls the pipeline while it iterates.
- The unit releases the stall in the cycle its result is valid, so the E/M pipeline register captures the result on that edge.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_step.sv | 24 ++
 rtl/muldiv_sequencer.sv | 86 ++++++++
 tb/tb_muldiv_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit
package muldiv_pkg;
    localparam int XLEN_DEFAULT = 32;
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    localparam logic [XLEN_DEFAULT-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN_DEFAULT-1:0] INT_MIN = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   rem,
    input  logic [XLEN-1:0]   opb,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next,
    output logic [XLEN-1:0]   rem_next
);
    logic [XLEN:0] sum, shifted, diff;
    // multiply keeps the multiplier in acc's low half and shifts the product in from the top;
    // divide shifts the dividend out of acc's low half and the quotient bits in behind it
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        shifted  = {rem, acc[XLEN-1]};
        diff     = shifted - {1'b0, opb};
        acc_next = is_div ? {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~diff[XLEN]} : {sum, acc[XLEN-1:1]};
        rem_next = is_div ? (diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]) : rem;
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit that stalls the pipeline while it iterates
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [2:0]        f3;
    logic [2*XLEN-1:0] acc, acc_next, prod;
    logic [XLEN-1:0]   rem, rem_next, opb, ma, mb, quo, rmd, val;
    logic              neg, a_neg, b_neg, dz, ov, is_div;
    always_comb begin
        a_neg  = srca[XLEN-1] & (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
        b_neg  = srcb[XLEN-1] & (funct3 inside {F3_MULH, F3_DIV, F3_REM});
        ma     = a_neg ? -srca : srca;
        mb     = b_neg ? -srcb : srcb;
        dz     = (funct3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU}) & (srcb == '0);
        ov     = (funct3 inside {F3_DIV, F3_REM}) & (srca == INT_MIN) & (srcb == '1);
        is_div = f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
        prod   = neg ? -acc : acc;
        quo    = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd    = neg ? -rem : rem;
        val    = !is_div ? (f3 == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                         : (f3 inside {F3_REM, F3_REMU} ? rmd : quo);
    end
    assign busy   = state == ITER;
    assign stall  = (state == IDLE & start & ~flush) | busy;
    assign done   = (state == DONE) & ~flush & ~reset;
    assign result = done ? val : '0;
    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc(acc), .rem(rem), .opb(opb), .is_div(is_div), .acc_next(acc_next), .rem_next(rem_next)
    );
    // special cases park their final value in acc/rem with neg=0 so the DONE mux needs no extra path
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            f3    <= '0;
            acc   <= '0;
            rem   <= '0;
            opb   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !flush) begin
                    f3  <= funct3;
                    opb <= mb;
                    rem <= dz ? srca : '0;
                    if (dz || ov) begin
                        acc   <= {{XLEN{1'b0}}, dz ? DIV_BY_ZERO_Q : INT_MIN};
                        neg   <= 1'b0;
                        state <= DONE;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, ma};
                        neg   <= (funct3 inside {F3_REM, F3_REMU}) ? a_neg : (a_neg ^ b_neg);
                        cnt   <= CNTW'(XLEN);
                        state <= ITER;
                    end
                end
                ITER: if (flush) begin
                    state <= IDLE;
                end else begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt - CNTW'(1);
                    if (cnt == CNTW'(1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of the RV32M sequencer against an arithmetic model
module tb_muldiv_sequencer;
    import muldiv_pkg::*;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] srca = '0, srcb = '0;
    logic        stall, busy, done;
    logic [31:0] result;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .srca(srca), .srcb(srcb),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    localparam logic [2:0]  AF [6] = '{F3_MUL, F3_DIV, F3_REM, F3_MULHU, F3_MULH, F3_MULHSU};
    localparam logic [31:0] AA [6] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] AB [6] = '{32'd6, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] AE [6] = '{32'd42, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
    localparam logic [2:0]  SF [4] = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    localparam logic [31:0] SA [4] = '{32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000};
    localparam logic [31:0] SB [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] SE [4] = '{32'hFFFF_FFFF, 32'd123, 32'h8000_0000, 32'h0};

    // RV32M semantics straight from the ISA rules using 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, su, sp;
        logic [63:0]        up;
        logic signed [31:0] qa, qb, qr;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        su = {32'd0, b};
        up = {32'd0, a} * {32'd0, b};
        qa = a;
        qb = b;
        r  = '0;
        case (f)
            3'd0: begin sp = sa * sb; r = sp[31:0]; end
            3'd1: begin sp = sa * sb; r = sp[63:32]; end
            3'd2: begin sp = sa * su; r = sp[63:32]; end
            3'd3: r = up[63:32];
            3'd4: if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == '1) r = a; else begin qr = qa / qb; r = qr; end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: if (b == 0) r = a; else if (a == 32'h8000_0000 && b == '1) r = '0; else begin qr = qa % qb; r = qr; end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == '1))) ? 1 : 33;
    endfunction

    function automatic logic [63:0] smask(input int l);
        return (64'd1 << l) - 64'd1;
    endfunction

    function automatic logic [63:0] bmask(input int l);
        return (l == 33) ? (smask(33) & ~64'd1) : 64'd0;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // issues one op in the cycle after the next edge and records outputs per cycle until done
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input bit hold, output int dcyc, output logic [31:0] res,
                          output logic [63:0] sh, output logic [63:0] bh, output int nz);
        dcyc = -1; res = '0; sh = '0; bh = '0; nz = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; srca = a; srcb = b;
        for (int c = 0; c < 60 && dcyc < 0; c++) begin
            @(negedge clk);
            sh[c] = stall;
            bh[c] = busy;
            if (done) begin
                dcyc = c;
                res  = result;
            end else if (result !== 32'd0) nz++;
            if (dcyc < 0) begin
                @(posedge clk); #1;
                start = hold;
                if (scramble) begin funct3 = 3'($urandom); srca = $urandom; srcb = $urandom; end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({stall, busy, done} !== 3'b000 || result !== 32'd0) begin
            bad++; $display("FAIL reset_outputs: got stall=%b busy=%b done=%b result=%h want all 0", stall, busy, done, result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_arith();
        int d, nz; logic [31:0] r; logic [63:0] sh, bh;
        for (int i = 0; i < 6; i++) begin
            run_op(AF[i], AA[i], AB[i], 1'b0, 1'b0, d, r, sh, bh, nz);
            total++; if (d !== 33) begin bad++; $display("FAIL arith%0d_latency: got %0d want 33", i, d); end
            total++; if (r !== AE[i]) begin bad++; $display("FAIL arith%0d_result: got %h want %h", i, r, AE[i]); end
            total++; if (sh !== smask(33)) begin bad++; $display("FAIL arith%0d_stall: got %h want %h", i, sh, smask(33)); end
            total++; if (bh !== bmask(33)) begin bad++; $display("FAIL arith%0d_busy: got %h want %h", i, bh, bmask(33)); end
            total++; if (nz !== 0) begin bad++; $display("FAIL arith%0d_idle_result: got %0d nonzero cycles want 0", i, nz); end
        end
    endtask

    task automatic test_special();
        int d, nz; logic [31:0] r; logic [63:0] sh, bh;
        for (int i = 0; i < 4; i++) begin
            run_op(SF[i], SA[i], SB[i], 1'b0, 1'b0, d, r, sh, bh, nz);
            total++; if (d !== 1) begin bad++; $display("FAIL special%0d_latency: got %0d want 1", i, d); end
            total++; if (r !== SE[i]) begin bad++; $display("FAIL special%0d_result: got %h want %h", i, r, SE[i]); end
            total++; if (sh !== 64'd1 || bh !== 64'd0) begin bad++; $display("FAIL special%0d_stall_busy: got %h/%h want 1/0", i, sh, bh); end
        end
    endtask

    task automatic test_random(input int n, input bit scramble);
        int d, nz, el; logic [31:0] r, a, b, e; logic [2:0] f; logic [63:0] sh, bh;
        for (int i = 0; i < n; i++) begin
            f = 3'($urandom); a = rnd_operand(); b = rnd_operand();
            e = model(f, a, b); el = model_lat(f, a, b);
            run_op(f, a, b, scramble, 1'b0, d, r, sh, bh, nz);
            total++; if (d !== el) begin bad++; $display("FAIL rand_latency f=%0d a=%h b=%h: got %0d want %0d", f, a, b, d, el); end
            total++; if (r !== e) begin bad++; $display("FAIL rand_result f=%0d a=%h b=%h scr=%0d: got %h want %h", f, a, b, scramble, r, e); end
            total++; if (sh !== smask(el) || bh !== bmask(el)) begin bad++; $display("FAIL rand_stall_busy f=%0d: got %h/%h want %h/%h", f, sh, bh, smask(el), bmask(el)); end
            total++; if (nz !== 0) begin bad++; $display("FAIL rand_idle_result f=%0d: got %0d nonzero cycles want 0", f, nz); end
        end
    endtask

    task automatic test_back_to_back();
        int d, nz; logic [31:0] r, a, b; logic [63:0] sh, bh;
        for (int k = 0; k < 2; k++) begin
            a = $urandom; b = (k == 0) ? $urandom : 32'd0;
            run_op(k == 0 ? F3_MUL : F3_DIVU, a, b, 1'b0, 1'b1, d, r, sh, bh, nz);
            total++; if (d !== model_lat(k == 0 ? F3_MUL : F3_DIVU, a, b) || r !== model(k == 0 ? F3_MUL : F3_DIVU, a, b)) begin
                bad++; $display("FAIL b2b%0d_first: got cycle %0d result %h want %0d/%h", k, d, r, model_lat(k == 0 ? F3_MUL : F3_DIVU, a, b), model(k == 0 ? F3_MUL : F3_DIVU, a, b));
            end
            total++; if (sh[d] !== 1'b0) begin bad++; $display("FAIL b2b%0d_done_stall: got %b want 0", k, sh[d]); end
            a = $urandom; b = $urandom | 32'd1;
            run_op(F3_MULHU, a, b, 1'b0, 1'b0, d, r, sh, bh, nz);
            total++; if (d !== 33) begin bad++; $display("FAIL b2b%0d_second_latency: got %0d want 33", k, d); end
            total++; if (r !== model(F3_MULHU, a, b)) begin bad++; $display("FAIL b2b%0d_second_result: got %h want %h", k, r, model(F3_MULHU, a, b)); end
        end
    endtask

    task automatic test_flush();
        int d, nz, dn; logic [31:0] r; logic [63:0] sh, bh; logic b10, b11, s11;
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = F3_MUL; srca = 32'd9; srcb = 32'd9;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_idle_accept: got busy=%b done=%b want 0/0", busy, done); end
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_DIVU; srca = $urandom; srcb = $urandom | 32'd1;
        dn = 0; b10 = 1'b0; b11 = 1'b1; s11 = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (c == 10) b10 = busy;
            if (c == 11) begin b11 = busy; s11 = stall; end
            if (c < 11) begin @(posedge clk); #1; start = 1'b0; flush = (c == 9); end
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL flush_no_done: got %0d done cycles want 0", dn); end
        total++; if (b10 !== 1'b1) begin bad++; $display("FAIL flush_busy_c10: got %b want 1", b10); end
        total++; if (b11 !== 1'b0 || s11 !== 1'b0) begin bad++; $display("FAIL flush_idle_c11: got busy=%b stall=%b want 0/0", b11, s11); end
        run_op(F3_MUL, 32'd3, 32'd5, 1'b0, 1'b0, d, r, sh, bh, nz);
        total++; if (d !== 33 || r !== 32'd15) begin bad++; $display("FAIL flush_next_op: got cycle %0d result %h want 33/0000000f", d, r); end
    endtask

    task automatic test_flush_done();
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_DIVU; srca = 32'd77; srcb = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
            bad++; $display("FAIL flush_done: got done=%b result=%h stall=%b want 0/0/0", done, result, stall);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_done_after: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_reset_mid();
        int viol, dn; logic b19;
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_MUL; srca = $urandom; srcb = $urandom;
        viol = 0; dn = 0; b19 = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (c == 19) b19 = busy;
            if (c >= 21 && ({stall, busy, done} !== 3'b000 || result !== 32'd0)) viol++;
            @(posedge clk); #1;
            start = 1'b0; reset = (c == 19);
        end
        total++; if (b19 !== 1'b1) begin bad++; $display("FAIL reset_mid_busy: got %b want 1", b19); end
        total++; if (dn !== 0) begin bad++; $display("FAIL reset_mid_no_done: got %0d done cycles want 0", dn); end
        total++; if (viol !== 0) begin bad++; $display("FAIL reset_mid_outputs: got %0d nonzero cycles want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_random(30, 1'b0);
        test_random(4, 1'b1);
        test_back_to_back();
        test_flush();
        test_flush_done();
        test_reset_mid();
        test_random(4, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
